decode_stage: RTL
=================

# decode_stage

RV32I instruction-decode stage, between the IF/ID boundary and the execute stage. It decodes the fetched instruction, drives the register-file read addresses, and captures the read data. It also detects load-use hazards against the instruction it holds, and registers everything into the ID/EX pipeline register with valid, stall and flush handling.

## Interface
- `DATA_W`, 32: datapath and immediate width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `if_valid` in 1: IF/ID holds an instruction.
- `if_instr` in 32: instruction word.
- `if_pc` in 32: instruction PC.
- `if_ready` out 1: ID accepts the IF/ID instruction this cycle; 0 means IF/ID must hold.
- `rf_rs1`, `rf_rs2` out 5: register-file read addresses, combinational from `if_instr[19:15]` and `[24:20]`.
- `rf_rd1`, `rf_rd2` in 32: register-file read data, combinational, with write-through forwarding already applied.
- `ex_stall` in 1: execute cannot accept; ID/EX holds its contents.
- `ex_flush` in 1: branch/jump redirect; kill ID/EX and discard the ID instruction.
- `id_valid` out 1: ID/EX holds a live instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` out 32: registered operands and immediate.
- `id_rs1`, `id_rs2`, `id_rd` out 5: registered register indices, for forwarding and writeback.
- `id_funct3` out 3.
- `id_alu_op` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- `id_alu_src`, `id_pc_src_a` out 1 each: ALU operand B is the immediate; ALU operand A is the PC.
- `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_branch`, `id_jump`, `id_jalr` out 1 each.
- `id_illegal` out 1: illegal opcode (see Configuration).

## Operation
- Decodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Immediates for I/S/B/U/J formats are sign-extended to 32 bits; B and J immediates have bit 0 = 0.
- ALU op mapping:
  - SUB only for OP with funct7[5]=1, funct3=000.
  - SRA for funct7[5]=1, funct3=101 (OP and OP-IMM).
  - LUI uses PASSB.
  - AUIPC, JAL and JALR use ADD with `id_pc_src_a`=1 for AUIPC and JAL.
- `id_reg_write` is 0 when rd=0.
- Source usage:
  - rs1 is used by everything except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH only.
- Load-use hazard: `id_valid & id_mem_read & id_rd!=0 & ((uses_rs1 & rs1==id_rd) | (uses_rs2 & rs2==id_rd)) & if_valid`.
- Priority per cycle, highest first:
  1. `ex_flush`: `if_ready`=1 (instruction consumed and dropped). Next cycle `id_valid`=0.
  2. `ex_stall`: `if_ready`=0. All ID/EX registers hold.
  3. Hazard: `if_ready`=0. ID/EX loads a bubble (`id_valid`=0 and all control bits cleared). Next cycle the hazard is gone and the instruction advances.
  4. Otherwise: `if_ready`=1. ID/EX loads the decoded instruction with `id_valid`=`if_valid`.
- A bubble or invalid entry always has `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_branch`, `id_jump` and `id_jalr` all 0. Datapath fields are don't-care.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on the `id_*` outputs after edge N.
- `rf_rs1` and `rf_rs2` are valid in the same cycle as `if_instr`. Read data is sampled at the same edge as the instruction.
- A WB write in the same cycle is visible through the register file's forwarding path; no extra stall is needed.
- `if_ready` is combinational from `if_valid`, `if_instr`, the ID/EX state, `ex_stall` and `ex_flush`.
- Reset (`rst`=0 at a rising edge):
  - all `id_*` outputs become 0;
  - `id_valid`=0;
  - this holds regardless of stall or hazard state.
  - While in reset, `if_ready` reads 1.
- A load-use hazard costs exactly one bubble.
- `ex_stall` held for K cycles freezes ID/EX for K cycles. The hazard is re-evaluated after release.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - An unrecognised opcode, or `if_instr[1:0]`!=2'b11, sets `id_illegal`=1 in the ID/EX entry.
  - All write, memory and branch controls are forced to 0.
  - `id_valid` stays 1 so execute can trap.
- `DECODE_ILLEGAL_EN` undefined:
  - `id_illegal` is tied 0.
  - Unrecognised encodings decode as a NOP: `id_valid`=1 and all controls 0.

## Test plan
- `0x00500093` (addi x1,x0,5) with `if_valid`=1 -> next cycle:
  - `id_valid`=1, `id_rd`=1, `id_imm`=5;
  - `id_alu_op`=0, `id_alu_src`=1, `id_reg_write`=1.
- `0x0000A103` (lw x2,0(x1)), then `0x001101B3` (add x3,x2,x1):
  - `if_ready`=0 for one cycle and one bubble is inserted (`id_valid`=0);
  - the add then issues with `id_rs1`=2.
- `0xFE000EE3` (beq x0,x0,-4) -> `id_imm`=0xFFFFFFFC, `id_branch`=1, `id_reg_write`=0.
- `ex_flush`=1 while a valid add is in IF/ID and a hazard is active -> `if_ready`=1, and next cycle `id_valid`=0 with all controls 0.
- `ex_stall`=1 for 3 cycles -> `id_*` outputs unchanged and `if_ready`=0. Then `rst`=0 during the stall -> all outputs 0 after the edge.
- `0xFFFFFFFF`:
  - with `DECODE_ILLEGAL_EN` -> `id_illegal`=1, `id_valid`=1, `id_reg_write`=0;
  - without it -> `id_illegal`=0 and all controls 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes IF/ID, reads the register file, detects load-use hazards
// and registers the result into ID/EX. Define DECODE_ILLEGAL_EN to flag illegal opcodes.
module decode_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc,
  output logic              if_ready,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              id_valid,
  output logic [31:0]       id_pc,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [4:0]        id_rs1,
  output logic [4:0]        id_rs2,
  output logic [4:0]        id_rd,
  output logic [2:0]        id_funct3,
  output logic [3:0]        id_alu_op,
  output logic              id_alu_src,
  output logic              id_pc_src_a,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_reg_write,
  output logic              id_branch,
  output logic              id_jump,
  output logic              id_jalr,
  output logic              id_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              pc_src_a;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              branch;
    logic              jump;
    logic              jalr;
    logic              illegal;
  } idex_t;

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic f7b5, input logic is_op);
    case (f3)
      3'b000:  alu_sel = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_sel = ALU_SLL;
      3'b010:  alu_sel = ALU_SLT;
      3'b011:  alu_sel = ALU_SLTU;
      3'b100:  alu_sel = ALU_XOR;
      3'b101:  alu_sel = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_sel = ALU_OR;
      default: alu_sel = ALU_AND;
    endcase
  endfunction

  logic [6:0]        opcode;
  logic [4:0]        rs1, rs2, rd;
  logic [2:0]        funct3;
  logic              f7b5;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic              uses_rs1, uses_rs2, hazard;
  idex_t             dec, ex_d, ex_q;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign funct3 = if_instr[14:12];
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign f7b5   = if_instr[30];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  assign imm_i = {{(DATA_W-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{(DATA_W-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{(DATA_W-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {{(DATA_W-31){if_instr[31]}}, if_instr[30:12], 12'b0};
  assign imm_j = {{(DATA_W-21){if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  // Unrecognised opcodes fall through the case with every control at 0, i.e. a NOP.
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = if_pc;
    dec.rs1_data = rf_rd1;
    dec.rs2_data = rf_rd2;
    dec.imm      = imm_i;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.funct3   = funct3;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    case (opcode)
      OPC_LUI:    begin dec.imm = imm_u; dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1;
                        dec.reg_write = 1'b1; end
      OPC_AUIPC:  begin dec.imm = imm_u; dec.alu_src = 1'b1; dec.pc_src_a = 1'b1;
                        dec.reg_write = 1'b1; end
      OPC_JAL:    begin dec.imm = imm_j; dec.alu_src = 1'b1; dec.pc_src_a = 1'b1;
                        dec.jump = 1'b1; dec.reg_write = 1'b1; end
      OPC_JALR:   begin dec.alu_src = 1'b1; dec.jump = 1'b1; dec.jalr = 1'b1;
                        dec.reg_write = 1'b1; uses_rs1 = 1'b1; end
      OPC_BRANCH: begin dec.imm = imm_b; dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_LOAD:   begin dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
                        uses_rs1 = 1'b1; end
      OPC_STORE:  begin dec.imm = imm_s; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
                        uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_OPIMM:  begin dec.alu_op = alu_sel(funct3, f7b5, 1'b0); dec.alu_src = 1'b1;
                        dec.reg_write = 1'b1; uses_rs1 = 1'b1; end
      OPC_OP:     begin dec.alu_op = alu_sel(funct3, f7b5, 1'b1); dec.reg_write = 1'b1;
                        uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      default:    ;
    endcase
    if (rd == 5'd0) dec.reg_write = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                   OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP});
`endif
  end

  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && if_valid &&
                  ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

  assign if_ready = !rst || ex_flush || (!ex_stall && !hazard);

  // Flush, bubble and empty slots all load an all-zero entry.
  always_comb begin
    ex_d = ex_q;
    if (ex_flush)      ex_d = '0;
    else if (ex_stall) ex_d = ex_q;
    else if (hazard)   ex_d = '0;
    else if (if_valid) ex_d = dec;
    else               ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign id_valid     = ex_q.valid;
  assign id_pc        = ex_q.pc;
  assign id_rs1_data  = ex_q.rs1_data;
  assign id_rs2_data  = ex_q.rs2_data;
  assign id_imm       = ex_q.imm;
  assign id_rs1       = ex_q.rs1;
  assign id_rs2       = ex_q.rs2;
  assign id_rd        = ex_q.rd;
  assign id_funct3    = ex_q.funct3;
  assign id_alu_op    = ex_q.alu_op;
  assign id_alu_src   = ex_q.alu_src;
  assign id_pc_src_a  = ex_q.pc_src_a;
  assign id_mem_read  = ex_q.mem_read;
  assign id_mem_write = ex_q.mem_write;
  assign id_reg_write = ex_q.reg_write;
  assign id_branch    = ex_q.branch;
  assign id_jump      = ex_q.jump;
  assign id_jalr      = ex_q.jalr;
  assign id_illegal   = ex_q.illegal;

endmodule
